// File: rtl/circle_cmd_ctrl.sv
// circle_cmd_ctrl
// Turns keypad presses into position/size commands for the VGA circle
// renderer. Each rising edge of key_ready with a valid code is queued in a
// 4-deep FIFO. At most one update is applied per frame, at the frame tick
// (vertical blank), so the drawn circle never tears mid-frame. All results
// are clamped so the circle stays fully on the 640x480 screen. When the
// queue is empty and auto_en is set, the circle bounces around on its own.

module circle_cmd_ctrl #(
   parameter int X_INIT    = 320,
   parameter int Y_INIT    = 240,
   parameter int R_INIT    = 15,
   parameter int STEP_XY   = 20,
   parameter int STEP_R    = 5,
   parameter int R_MIN     = 5,
   parameter int R_MAX     = 200,
   parameter int AUTO_STEP = 2,
   parameter int H_RES     = 640,
   parameter int V_RES     = 480
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_code,
   input  logic       key_ready,
   input  logic       frame_tick,
   input  logic       auto_en,
   output logic [9:0] cx,
   output logic [8:0] cy,
   output logic [9:0] radius,
   output logic [2:0] pending,
   output logic       overflow
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_APPLY,
      ST_AUTO
   } state_t;

   typedef enum logic [2:0] {
      CMD_LEFT,
      CMD_RIGHT,
      CMD_UP,
      CMD_DOWN,
      CMD_SHRINK,
      CMD_GROW,
      CMD_CENTRE
   } cmd_t;

   // 12-bit signed working range: large enough that no intermediate sum or
   // difference of the 10-bit quantities can wrap.
   localparam logic signed [11:0] C_X_INIT  = 12'(X_INIT);
   localparam logic signed [11:0] C_Y_INIT  = 12'(Y_INIT);
   localparam logic signed [11:0] C_R_INIT  = 12'(R_INIT);
   localparam logic signed [11:0] C_STEP_XY = 12'(STEP_XY);
   localparam logic signed [11:0] C_STEP_R  = 12'(STEP_R);
   localparam logic signed [11:0] C_R_MIN   = 12'(R_MIN);
   localparam logic signed [11:0] C_R_MAX   = 12'(R_MAX);
   localparam logic signed [11:0] C_AUTO    = 12'(AUTO_STEP);
   localparam logic signed [11:0] C_HI_X    = 12'(H_RES - 1);
   localparam logic signed [11:0] C_HI_Y    = 12'(V_RES - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_key_ready_d;
   cmd_t        r_fifo [4];
   logic [1:0]  r_wr_ptr;
   logic [1:0]  r_rd_ptr;
   logic [2:0]  r_count;
   logic        r_overflow;
   cmd_t        r_cmd;

   logic [9:0]  r_cx;
   logic [8:0]  r_cy;
   logic [9:0]  r_radius;
   logic        r_dir_x;   // 1 = moving toward +x
   logic        r_dir_y;   // 1 = moving toward +y

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   logic        w_key_valid;
   cmd_t        w_key_cmd;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_push_ok;

   logic signed [11:0] w_cx_s;
   logic signed [11:0] w_cy_s;
   logic signed [11:0] w_r_s;
   logic signed [11:0] w_max_x;
   logic signed [11:0] w_max_y;
   logic signed [11:0] w_room_r;
   logic signed [11:0] w_room_d;
   logic signed [11:0] w_left;
   logic signed [11:0] w_right;
   logic signed [11:0] w_up;
   logic signed [11:0] w_down;
   logic signed [11:0] w_shrink;
   logic signed [11:0] w_ax_pos;
   logic signed [11:0] w_ax_neg;
   logic signed [11:0] w_ay_pos;
   logic signed [11:0] w_ay_neg;
   logic signed [11:0] w_grow;

   logic signed [11:0] w_cx_nxt;
   logic signed [11:0] w_cy_nxt;
   logic signed [11:0] w_r_nxt;
   logic               w_dir_x_nxt;
   logic               w_dir_y_nxt;
   logic               w_load;

   // Clamping keeps every result in range, so the top bits of the working
   // values are always zero when loaded; they are collected here only so
   // they are visibly accounted for.
   logic               w_unused;
   assign w_unused = ^{w_cx_nxt[11:10], w_cy_nxt[11:9], w_r_nxt[11:10]};

   // ------------------------------------------------------------------
   // Key capture
   // ------------------------------------------------------------------

   // Map the keypad code to a command; unknown codes are flagged invalid.
   // NOTE: combinational blocks assign every output a default first so no
   // path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      w_key_valid = 1'b1;
      w_key_cmd   = CMD_LEFT;
      case (key_code)
         5'h0C:   w_key_cmd = CMD_LEFT;
         5'h0E:   w_key_cmd = CMD_RIGHT;
         5'h09:   w_key_cmd = CMD_UP;
         5'h11:   w_key_cmd = CMD_DOWN;
         5'h10:   w_key_cmd = CMD_SHRINK;
         5'h12:   w_key_cmd = CMD_GROW;
         5'h0D:   w_key_cmd = CMD_CENTRE;
         default: w_key_valid = 1'b0;
      endcase
   end

   // Remember last cycle's key_ready so a held key yields a single command.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) r_key_ready_d <= 1'b0;
      else     r_key_ready_d <= key_ready;
   end

   assign w_push    = key_ready && !r_key_ready_d && w_key_valid;
   assign w_pop     = (r_state == ST_FETCH) && (r_count != 3'd0);
   assign w_full    = (r_count == 3'd4);
   // A push while full still fits if the head leaves in the same cycle.
   assign w_push_ok = w_push && (!w_full || w_pop);

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------

   // FIFO storage write port.
   // NOTE: the storage array has no reset; validity is tracked entirely by
   // the pointers and count, which are reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_fifo[r_wr_ptr] <= w_key_cmd;
   end

   // FIFO pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_count    <= 3'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
         if (w_push_ok && !w_pop)      r_count <= r_count + 3'd1;
         else if (!w_push_ok && w_pop) r_count <= r_count - 3'd1;
         if (w_push && !w_push_ok)     r_overflow <= 1'b1;
      end
   end

   // Latch the queue head while fetching so APPLY works from a stable copy.
   always_ff @(posedge clk) begin
      if (rst)        r_cmd <= CMD_LEFT;
      else if (w_pop) r_cmd <= r_fifo[r_rd_ptr];
   end

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: leave IDLE only on a frame tick; ticks elsewhere are ignored.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (frame_tick) begin
               if (r_count != 3'd0) w_state_nxt = ST_FETCH;
               else if (auto_en)    w_state_nxt = ST_AUTO;
            end
         end
         ST_FETCH: w_state_nxt = ST_APPLY;
         ST_APPLY: w_state_nxt = ST_IDLE;
         ST_AUTO:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Geometry datapath
   // ------------------------------------------------------------------

   assign w_cx_s   = $signed({2'b00, r_cx});
   assign w_cy_s   = $signed({3'b000, r_cy});
   assign w_r_s    = $signed({2'b00, r_radius});

   assign w_max_x  = C_HI_X - w_r_s;     // largest cx keeping the circle on screen
   assign w_max_y  = C_HI_Y - w_r_s;
   assign w_room_r = C_HI_X - w_cx_s;    // distance to the right / bottom edges
   assign w_room_d = C_HI_Y - w_cy_s;

   assign w_left   = w_cx_s - C_STEP_XY;
   assign w_right  = w_cx_s + C_STEP_XY;
   assign w_up     = w_cy_s - C_STEP_XY;
   assign w_down   = w_cy_s + C_STEP_XY;
   assign w_shrink = w_r_s - C_STEP_R;

   assign w_ax_pos = w_cx_s + C_AUTO;
   assign w_ax_neg = w_cx_s - C_AUTO;
   assign w_ay_pos = w_cy_s + C_AUTO;
   assign w_ay_neg = w_cy_s - C_AUTO;

   // Grown radius limited by R_MAX and by the distance to every screen edge.
   always_comb begin
      w_grow = w_r_s + C_STEP_R;
      if (w_grow > C_R_MAX)  w_grow = C_R_MAX;
      if (w_grow > w_cx_s)   w_grow = w_cx_s;
      if (w_grow > w_cy_s)   w_grow = w_cy_s;
      if (w_grow > w_room_r) w_grow = w_room_r;
      if (w_grow > w_room_d) w_grow = w_room_d;
   end

   // Select the new geometry for APPLY (queued command) or AUTO (bounce).
   always_comb begin
      w_cx_nxt    = w_cx_s;
      w_cy_nxt    = w_cy_s;
      w_r_nxt     = w_r_s;
      w_dir_x_nxt = r_dir_x;
      w_dir_y_nxt = r_dir_y;
      w_load      = 1'b0;
      case (r_state)
         ST_APPLY: begin
            w_load = 1'b1;
            case (r_cmd)
               CMD_LEFT:   w_cx_nxt = (w_left  < w_r_s)   ? w_r_s   : w_left;
               CMD_RIGHT:  w_cx_nxt = (w_right > w_max_x) ? w_max_x : w_right;
               CMD_UP:     w_cy_nxt = (w_up    < w_r_s)   ? w_r_s   : w_up;
               CMD_DOWN:   w_cy_nxt = (w_down  > w_max_y) ? w_max_y : w_down;
               CMD_SHRINK: w_r_nxt  = (w_shrink < C_R_MIN) ? C_R_MIN : w_shrink;
               CMD_GROW:   w_r_nxt  = w_grow;
               CMD_CENTRE: begin
                  w_cx_nxt = C_X_INIT;
                  w_cy_nxt = C_Y_INIT;
                  w_r_nxt  = C_R_INIT;
               end
               default: ;
            endcase
         end
         ST_AUTO: begin
            w_load = 1'b1;
            // On crossing a bound, park on the bound and reverse that axis.
            if (r_dir_x) begin
               if (w_ax_pos > w_max_x) begin
                  w_cx_nxt    = w_max_x;
                  w_dir_x_nxt = 1'b0;
               end else begin
                  w_cx_nxt = w_ax_pos;
               end
            end else begin
               if (w_ax_neg < w_r_s) begin
                  w_cx_nxt    = w_r_s;
                  w_dir_x_nxt = 1'b1;
               end else begin
                  w_cx_nxt = w_ax_neg;
               end
            end
            if (r_dir_y) begin
               if (w_ay_pos > w_max_y) begin
                  w_cy_nxt    = w_max_y;
                  w_dir_y_nxt = 1'b0;
               end else begin
                  w_cy_nxt = w_ay_pos;
               end
            end else begin
               if (w_ay_neg < w_r_s) begin
                  w_cy_nxt    = w_r_s;
                  w_dir_y_nxt = 1'b1;
               end else begin
                  w_cy_nxt = w_ay_neg;
               end
            end
         end
         default: ;
      endcase
   end

   // Geometry and bounce-direction registers, updated once per applied frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cx     <= 10'(X_INIT);
         r_cy     <= 9'(Y_INIT);
         r_radius <= 10'(R_INIT);
         r_dir_x  <= 1'b1;
         r_dir_y  <= 1'b1;
      end else if (w_load) begin
         r_cx     <= w_cx_nxt[9:0];
         r_cy     <= w_cy_nxt[8:0];
         r_radius <= w_r_nxt[9:0];
         r_dir_x  <= w_dir_x_nxt;
         r_dir_y  <= w_dir_y_nxt;
      end
   end

   assign cx       = r_cx;
   assign cy       = r_cy;
   assign radius   = r_radius;
   assign pending  = r_count;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_circle_cmd_ctrl.sv
// Directed bench for circle_cmd_ctrl. Inputs are driven and outputs sampled
// on the falling edge; expected values are hand-computed from the behaviour
// of the block (steps of 20/5, clamps against radius and 639/479 - radius).

module tb_circle_cmd_ctrl;

   localparam logic [4:0] K_LEFT   = 5'h0C;
   localparam logic [4:0] K_RIGHT  = 5'h0E;
   localparam logic [4:0] K_SHRINK = 5'h10;
   localparam logic [4:0] K_GROW   = 5'h12;
   localparam logic [4:0] K_CENTRE = 5'h0D;

   logic       clk;
   logic       rst;
   logic [4:0] key_code;
   logic       key_ready;
   logic       frame_tick;
   logic       auto_en;
   logic [9:0] cx;
   logic [8:0] cy;
   logic [9:0] radius;
   logic [2:0] pending;
   logic       overflow;

   int n_checks;
   int n_errors;

   circle_cmd_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .frame_tick (frame_tick),
      .auto_en    (auto_en),
      .cx         (cx),
      .cy         (cy),
      .radius     (radius),
      .pending    (pending),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if it differs.
   task automatic check(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      key_code   = 5'h00;
      key_ready  = 1'b0;
      frame_tick = 1'b0;
      auto_en    = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   // One key edge held for a single cycle; the push is visible on return.
   task automatic press(input logic [4:0] code);
      key_code  = code;
      key_ready = 1'b1;
      cyc(1);
      key_ready = 1'b0;
      cyc(1);
   endtask

   // One-cycle frame tick; returns just after the tick's clock edge.
   task automatic tick();
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
   endtask

   // Queue a command and let the next frame apply it (update at tick+2).
   task automatic apply(input logic [4:0] code);
      press(code);
      tick();
      cyc(3);
   endtask

   // Watchdog: the sequence is fixed-length, so this only trips on a hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;

      // ---------------- reset state ----------------
      do_reset();
      check("rst_cx", cx, 320);
      check("rst_cy", cy, 240);
      check("rst_r", radius, 15);
      check("rst_pending", pending, 0);
      check("rst_overflow", overflow, 0);

      // ---------------- held key -> one command ----------------
      key_code  = K_RIGHT;
      key_ready = 1'b1;
      cyc(100);
      check("hold_pending", pending, 1);
      key_ready = 1'b0;
      cyc(1);
      tick();
      check("fetch_pending_t0", pending, 1);
      cyc(1);
      check("fetch_pending_t1", pending, 0);
      check("fetch_cx_t1", cx, 320);
      cyc(1);
      check("apply_cx_t2", cx, 340);
      cyc(2);
      tick();
      cyc(3);
      check("one_cmd_only", cx, 340);

      // invalid codes are never queued
      press(5'h00);
      press(5'h1F);
      check("invalid_pending", pending, 0);

      // ---------------- overflow ----------------
      do_reset();
      for (int i = 0; i < 5; i++) press(K_LEFT);
      check("ovf_pending", pending, 4);
      check("ovf_flag", overflow, 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         cyc(3);
         check($sformatf("ovf_drain_cx%0d", i), cx, 320 - 20 * i);
      end
      tick();
      cyc(3);
      check("ovf_fifth_tick_cx", cx, 240);
      check("ovf_drained", pending, 0);
      check("ovf_sticky", overflow, 1);

      // ---------------- GROW saturation, RIGHT clamp ----------------
      do_reset();
      apply(K_GROW);
      check("grow_first", radius, 20);
      for (int i = 0; i < 39; i++) apply(K_GROW);
      check("grow_rmax", radius, 200);
      for (int i = 0; i < 5; i++) apply(K_RIGHT);
      check("right_420", cx, 420);
      apply(K_RIGHT);
      check("right_clamp", cx, 439);
      apply(K_GROW);
      check("grow_at_edge", radius, 200);
      check("grow_cy", cy, 240);

      // ---------------- SHRINK floor, LEFT floor ----------------
      do_reset();
      apply(K_SHRINK);
      check("shrink_10", radius, 10);
      apply(K_SHRINK);
      check("shrink_5", radius, 5);
      apply(K_SHRINK);
      check("shrink_floor", radius, 5);
      for (int i = 0; i < 15; i++) apply(K_LEFT);
      check("left_20", cx, 20);
      apply(K_LEFT);
      check("left_clamp", cx, 5);
      apply(K_LEFT);
      check("left_stay", cx, 5);

      // ---------------- auto bounce ----------------
      do_reset();
      apply(K_SHRINK);
      apply(K_SHRINK);
      for (int i = 0; i < 15; i++) apply(K_RIGHT);
      check("auto_setup_cx", cx, 620);
      auto_en = 1'b1;
      tick();
      check("auto_t0_cx", cx, 620);
      cyc(1);
      check("auto_t1_cx", cx, 622);
      check("auto_t1_cy", cy, 242);
      for (int i = 0; i < 6; i++) begin
         cyc(2);
         tick();
         cyc(1);
      end
      check("auto_near_cx", cx, 634);
      check("auto_near_cy", cy, 254);
      cyc(2);
      tick();
      cyc(1);
      check("auto_bounce_cx", cx, 634);
      check("auto_bounce_cy", cy, 256);
      cyc(2);
      tick();
      cyc(1);
      check("auto_back_cx", cx, 632);
      check("auto_back_cy", cy, 258);
      check("auto_r", radius, 5);

      // a queued command wins over auto on the next tick
      cyc(2);
      press(K_LEFT);
      tick();
      cyc(1);
      check("prio_t1_cx", cx, 632);
      cyc(1);
      check("prio_t2_cx", cx, 612);
      check("prio_t2_cy", cy, 258);

      // CENTRE keeps the bounce direction (-x, +y)
      cyc(2);
      apply(K_CENTRE);
      check("centre_cx", cx, 320);
      check("centre_r", radius, 15);
      tick();
      cyc(1);
      check("centre_auto_cx", cx, 318);
      check("centre_auto_cy", cy, 242);
      auto_en = 1'b0;
      cyc(2);
      tick();
      cyc(3);
      check("auto_off_cx", cx, 318);

      // ---------------- push + pop while full ----------------
      do_reset();
      for (int i = 0; i < 4; i++) press(K_LEFT);
      check("full_pending", pending, 4);
      tick();
      key_code  = K_LEFT;
      key_ready = 1'b1;
      cyc(1);
      key_ready = 1'b0;
      check("pushpop_pending", pending, 4);
      check("pushpop_overflow", overflow, 0);
      cyc(1);
      check("pushpop_cx", cx, 300);

      // ---------------- reset during APPLY ----------------
      cyc(2);
      tick();
      cyc(1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("rstapply_cx", cx, 320);
      check("rstapply_cy", cy, 240);
      check("rstapply_r", radius, 15);
      check("rstapply_pending", pending, 0);
      check("rstapply_overflow", overflow, 0);
      tick();
      cyc(3);
      check("rstapply_discard", cx, 320);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
